modmul_product_seq: RTL and testbench

//  Sequential radix-2 shift-add multiplier; the stage directly upstream of barrett_parallel.

---
 rtl/modmul_product_seq_pkg.sv | 21 ++
 rtl/modmul_product_seq.sv | 122 ++++++++++++
 tb/tb_modmul_product_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/modmul_product_seq_pkg.sv
// ============================================================================
//  Module      : modmul_product_seq_pkg
//  Description : Shared widths and FSM state type for the shift-add multiplier
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package modmul_product_seq_pkg;

    localparam int MODULUS_LENGTH = 23;
    localparam int DATA_LENGTH    = 64;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

`default_nettype wire

// File: rtl/modmul_product_seq.sv
// ============================================================================
//  Module      : modmul_product_seq
//  Description : Radix-2 shift-add multiplier, fixed W-cycle latency, feeds
//                the Barrett reducer with a one-cycle finish strobe
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module modmul_product_seq #(
    parameter int OPERAND_WIDTH = modmul_product_seq_pkg::MODULUS_LENGTH,
    parameter int DATA_LENGTH   = modmul_product_seq_pkg::DATA_LENGTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [DATA_LENGTH-1:0] a_i,
    input  logic [DATA_LENGTH-1:0] b_i,
    output logic                   busy_o,
    output logic                   finish_o,
    output logic [DATA_LENGTH-1:0] product_o
);

    import modmul_product_seq_pkg::*;

    localparam int W     = OPERAND_WIDTH;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    if (2 * OPERAND_WIDTH > DATA_LENGTH) begin : g_width_check
        $fatal(1, "modmul_product_seq: 2*OPERAND_WIDTH exceeds DATA_LENGTH");
    end

    mul_state_e             state_q, state_d;
    logic [2*W-1:0]         a_sh_q, a_sh_d;
    logic [W-1:0]           b_sh_q, b_sh_d;
    logic [2*W-1:0]         acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_LENGTH-1:0] product_q, product_d;

    logic [2*W-1:0]         acc_sum;
    logic                   last_step;
    logic                   accept;
    logic                   unused_upper_bits;

    // Operand bits above W are intentionally discarded.
    assign unused_upper_bits = ^{a_i[DATA_LENGTH-1:W], b_i[DATA_LENGTH-1:W]};

    assign acc_sum   = acc_q + (b_sh_q[0] ? a_sh_q : '0);
    assign last_step = (cnt_q == CNT_W'(W - 1));
    assign accept    = start_i && ((state_q == MUL_IDLE) || (state_q == MUL_DONE));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= MUL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (start_i)   state_d = MUL_RUN;
            MUL_RUN:  if (last_step) state_d = MUL_DONE;
            MUL_DONE: state_d = start_i ? MUL_RUN : MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    always_comb begin
        busy_o    = 1'b0;
        finish_o  = 1'b0;
        product_o = product_q;
        case (state_q)
            MUL_RUN:  busy_o   = 1'b1;
            MUL_DONE: finish_o = 1'b1;
            default:  ;
        endcase
    end

    // Datapath: the result register only moves on the final step, so the
    // reducer sees a stable value between finish strobes.
    always_comb begin
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        if (accept) begin
            a_sh_d = (2*W)'(a_i[W-1:0]);
            b_sh_d = b_i[W-1:0];
            acc_d  = '0;
            cnt_d  = '0;
        end else if (state_q == MUL_RUN) begin
            acc_d  = acc_sum;
            a_sh_d = a_sh_q << 1;
            b_sh_d = b_sh_q >> 1;
            cnt_d  = cnt_q + 1'b1;
            if (last_step) begin
                product_d = DATA_LENGTH'(acc_sum);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_modmul_product_seq.sv
// ============================================================================
//  Module      : tb_modmul_product_seq
//  Description : Self-checking bench for modmul_product_seq (W=23)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modmul_product_seq;

    localparam int W   = 23;
    localparam int DL  = 64;
    localparam int LAT = W;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic [DL-1:0] a_i = '0;
    logic [DL-1:0] b_i = '0;
    logic          busy_o;
    logic          finish_o;
    logic [DL-1:0] product_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DL-1:0] last_prod = '0;

    modmul_product_seq dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .busy_o    (busy_o),
        .finish_o  (finish_o),
        .product_o (product_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [DL-1:0] ref_mul(input logic [DL-1:0] a, input logic [DL-1:0] b);
        longint unsigned am, bm;
        am = longint'(a) % (64'd1 << W);
        bm = longint'(b) % (64'd1 << W);
        return am * bm;
    endfunction

    // Caller sits on a negedge; returns on the negedge after the start edge.
    task automatic launch(input logic [DL-1:0] a, input logic [DL-1:0] b);
        a_i = a;
        b_i = b;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Observe from k=0 until finish_o is seen (returns on that negedge) or budget expires.
    task automatic wait_finish(input logic [DL-1:0] held, output int fin_k,
                               output int busy_cnt, output bit held_ok);
        fin_k = -1;
        busy_cnt = 0;
        held_ok = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (busy_o) begin
                busy_cnt++;
                if (product_o !== held) held_ok = 1'b0;
            end
            if (finish_o) begin
                fin_k = k;
                return;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        n_tests++;
        if ({busy_o, finish_o, product_o} !== {2'b00, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b finish=%b product=%h, required 0/0/0",
                     busy_o, finish_o, product_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        last_prod = '0;
    endtask

    task automatic test_job(input string name, input logic [DL-1:0] a,
                            input logic [DL-1:0] b, input logic [DL-1:0] exp);
        int fk, bc;
        bit hok;
        launch(a, b);
        wait_finish(last_prod, fk, bc, hok);
        n_tests++;
        if (fk !== LAT || bc !== W || !hok || product_o !== exp) begin
            n_fail++;
            $display("FAIL %s: finish_k=%0d busy=%0d held_ok=%0d product=%h, required %0d/%0d/1/%h",
                     name, fk, bc, hok, product_o, LAT, W, exp);
        end
        last_prod = exp;
        @(negedge clk_i);
        n_tests++;
        if (finish_o !== 1'b0 || busy_o !== 1'b0 || product_o !== exp) begin
            n_fail++;
            $display("FAIL %s_after: finish=%b busy=%b product=%h, required 0/0/%h",
                     name, finish_o, busy_o, product_o, exp);
        end
    endtask

    task automatic test_directed;
        test_job("mul_3x5",      64'd3,        64'd5,        64'hF);
        test_job("mul_max",      64'h7FE000,   64'h7FE000,   64'h3FE004000000);
        test_job("mul_zero",     64'd0,        64'h7FE000,   64'd0);
        test_job("mul_upper_ign", 64'h800003,  64'd2,        64'h6);
        test_job("mul_upper_b",  64'hFFFF_FFFF_FF80_0001, 64'hABCD_0000_0000_0004, 64'h4);
    endtask

    task automatic test_random;
        logic [DL-1:0] a, b;
        for (int i = 0; i < 12; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 4 == 0) a = a & 64'h7FFFFF;
            test_job("mul_random", a, b, ref_mul(a, b));
        end
    endtask

    task automatic test_stall_restart;
        int fk, bc, nfin;
        bit hok;
        launch(64'd7, 64'd9);
        fk = -1;
        for (int k = 0; k < 60; k++) begin
            if (k == 10) begin a_i = 64'd1; b_i = 64'd1; start_i = 1'b1; end
            if (k == 11) start_i = 1'b0;
            if (finish_o) begin fk = k; break; end
            @(negedge clk_i);
        end
        n_tests++;
        if (fk !== LAT || product_o !== 64'h3F) begin
            n_fail++;
            $display("FAIL stall_ignored: finish_k=%0d product=%h, required %0d/%h",
                     fk, product_o, LAT, 64'h3F);
        end
        last_prod = 64'h3F;
        launch(64'd2, 64'd4);
        wait_finish(last_prod, fk, bc, hok);
        n_tests++;
        if (fk !== LAT || bc !== W || !hok || product_o !== 64'h8) begin
            n_fail++;
            $display("FAIL restart_done: finish_k=%0d busy=%0d held_ok=%0d product=%h, required %0d/%0d/1/%h",
                     fk, bc, hok, product_o, LAT, W, 64'h8);
        end
        last_prod = 64'h8;
        nfin = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_i);
            if (finish_o || busy_o) nfin++;
        end
        n_tests++;
        if (nfin !== 0) begin
            n_fail++;
            $display("FAIL no_queued_job: active_cycles=%0d, required 0", nfin);
        end
    endtask

    task automatic test_back_to_back;
        int fk, bc;
        bit hok;
        logic [DL-1:0] a, b, exp;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        exp = ref_mul(a, b);
        a_i = a;
        b_i = b;
        start_i = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk_i);
            wait_finish(last_prod, fk, bc, hok);
            n_tests++;
            if (fk !== LAT || bc !== W || !hok || product_o !== exp) begin
                n_fail++;
                $display("FAIL back_to_back_%0d: finish_k=%0d busy=%0d held_ok=%0d product=%h, required %0d/%0d/1/%h",
                         j, fk, bc, hok, product_o, LAT, W, exp);
            end
            last_prod = exp;
        end
        start_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_reset_abort;
        int nact;
        launch(64'h7FE000, 64'h7FE000);
        repeat (10) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        n_tests++;
        if ({busy_o, finish_o, product_o} !== {2'b00, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_abort_outputs: busy=%b finish=%b product=%h, required 0/0/0",
                     busy_o, finish_o, product_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        nact = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_i);
            if (finish_o || busy_o || product_o !== 64'd0) nact++;
        end
        n_tests++;
        if (nact !== 0) begin
            n_fail++;
            $display("FAIL reset_abort_quiet: bad_cycles=%0d, required 0", nact);
        end
        last_prod = '0;
        test_job("after_reset_3x5", 64'd3, 64'd5, 64'hF);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_stall_restart;
        test_back_to_back;
        test_reset_abort;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
